// File: rtl/exec_pkg.sv
// Shared types for the execute sequencer: FSM states, ARM condition codes
// and flag bit positions within the 4-bit flags bus.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    typedef enum int {
        FLAG_V = 0,
        FLAG_N = 1,
        FLAG_C = 2,
        FLAG_Z = 3
    } flag_idx_t;

endpackage

// File: rtl/exec_cond_check.sv
// Combinational ARM condition-code evaluator: pass=1 when the op should execute.
// Only instantiated when EXEC_SEQ_COND_EN is defined.
module exec_cond_check
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: IDLE -> EXEC -> WB per op, one op every 2 cycles.
// Define EXEC_SEQ_COND_EN to gate write-back on the op's ARM condition code.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int UOP_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [UOP_W-1:0] op_uop,
    input  logic [SEL_W-1:0] op_rd,
    input  logic [SEL_W-1:0] op_rn,
    input  logic [SEL_W-1:0] op_rm,
    input  logic             op_wb,
    input  logic             op_setf,
    input  logic [3:0]       op_cond,
    input  logic [3:0]       flags,
    output logic [SEL_W-1:0] sel_p0,
    output logic [SEL_W-1:0] sel_p1,
    output logic [SEL_W-1:0] sel_in,
    output logic [UOP_W-1:0] alu_uop,
    output logic             reg_we,
    output logic             flags_we,
    output logic             busy,
    output logic             retire,
    output logic             skipped,
    output logic [CNT_W-1:0] op_count
);

    state_t           state, state_nx;
    logic             accept;
    logic             pass_now;
    logic             pass_p1;
    logic [SEL_W-1:0] rd_p0;
    logic             wb_p0, setf_p0;

    assign accept = op_valid & op_ready;

`ifdef EXEC_SEQ_COND_EN
    logic [3:0] cond_p0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    cond_p0 <= 4'd0;
        else if (accept) cond_p0 <= op_cond;
    end

    exec_cond_check u_cond (
        .cond  (cond_p0),
        .flags (flags),
        .pass  (pass_now)
    );

    assign skipped = (state == WB) & ~pass_p1;
`else
    logic unused_ok;
    assign unused_ok = ^{op_cond, flags};
    assign pass_now  = 1'b1;
    assign skipped   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Ready is asserted in WB so the next op enters EXEC right behind the write.
    always_comb begin
        state_nx = state;
        op_ready = 1'b1;
        busy     = 1'b0;
        retire   = 1'b0;
        reg_we   = 1'b0;
        flags_we = 1'b0;
        sel_in   = '0;
        case (state)
            IDLE: begin
                if (op_valid) state_nx = EXEC;
            end
            EXEC: begin
                op_ready = 1'b0;
                busy     = 1'b1;
                state_nx = WB;
            end
            WB: begin
                busy     = 1'b1;
                retire   = 1'b1;
                sel_in   = rd_p0;
                reg_we   = wb_p0 & pass_p1;
                flags_we = setf_p0 & pass_p1;
                state_nx = op_valid ? EXEC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Op capture on accept; read selects and uop hold until the next accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_p0  <= '0;
            sel_p1  <= '0;
            alu_uop <= '0;
            rd_p0   <= '0;
            wb_p0   <= 1'b0;
            setf_p0 <= 1'b0;
        end else if (accept) begin
            sel_p0  <= op_rn;
            sel_p1  <= op_rm;
            alu_uop <= op_uop;
            rd_p0   <= op_rd;
            wb_p0   <= op_wb;
            setf_p0 <= op_setf;
        end
    end

    // Condition result is frozen at the end of EXEC so WB is immune to flag changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass_p1  <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == EXEC) pass_p1 <= pass_now;
            if (state == WB)   op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus random traffic
// against a cycle-indexed transaction model; works with or without EXEC_SEQ_COND_EN.
module tb_exec_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [4:0]  op_uop = '0;
    logic [3:0]  op_rd = '0, op_rn = '0, op_rm = '0;
    logic        op_wb = 1'b0, op_setf = 1'b0;
    logic [3:0]  op_cond = 4'hE;
    logic [3:0]  flags;

    logic        op_ready, reg_we, flags_we, busy, retire, skipped;
    logic [3:0]  sel_p0, sel_p1, sel_in;
    logic [4:0]  alu_uop;
    logic [15:0] op_count;

    logic        op_ready_n, reg_we_n, flags_we_n, busy_n, retire_n, skipped_n;
    logic [3:0]  sel_p0_n, sel_p1_n, sel_in_n;
    logic [4:0]  alu_uop_n;
    logic [3:0]  op_count_n;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    exec_sequencer dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_uop(op_uop), .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm),
        .op_wb(op_wb), .op_setf(op_setf), .op_cond(op_cond), .flags(flags),
        .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in), .alu_uop(alu_uop),
        .reg_we(reg_we), .flags_we(flags_we), .busy(busy), .retire(retire),
        .skipped(skipped), .op_count(op_count)
    );

    exec_sequencer #(.CNT_W(4)) dut_n (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready_n),
        .op_uop(op_uop), .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm),
        .op_wb(op_wb), .op_setf(op_setf), .op_cond(op_cond), .flags(flags),
        .sel_p0(sel_p0_n), .sel_p1(sel_p1_n), .sel_in(sel_in_n), .alu_uop(alu_uop_n),
        .reg_we(reg_we_n), .flags_we(flags_we_n), .busy(busy_n), .retire(retire_n),
        .skipped(skipped_n), .op_count(op_count_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file and ALU (uop 0 = ADD, 1 = SUB) wrapped around the DUT.
    logic [31:0] rf [16];
    logic [3:0]  fl_reg;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [32:0] alu_s;
    logic        alu_c, alu_v;
    logic [3:0]  alu_fl;
    logic        preload = 1'b0, clr_flags = 1'b0, rand_mode = 1'b0;
    logic [3:0]  rnd_flags = '0;

    assign flags = rand_mode ? rnd_flags : fl_reg;

    always_comb begin
        alu_a = rf[sel_p0];
        alu_b = rf[sel_p1];
        alu_s = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (alu_uop == 5'd1) begin
            alu_r = alu_a - alu_b;
            alu_c = (alu_a >= alu_b);
            alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
        end else begin
            alu_s = {1'b0, alu_a} + {1'b0, alu_b};
            alu_r = alu_s[31:0];
            alu_c = alu_s[32];
            alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
        end
        alu_fl = {alu_r == 32'd0, alu_c, alu_r[31], alu_v};
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[0] <= 32'd2;
            rf[1] <= 32'd1;
        end else if (reg_we) begin
            rf[sel_in] <= alu_r;
        end
        if (clr_flags)     fl_reg <= 4'd0;
        else if (flags_we) fl_reg <= alu_fl;
    end

    // ARM conditions: cond[3:1] picks a predicate, cond[0] inverts it, 1111 never runs.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, n, v, base;
        z = f[3]; cf = f[2]; n = f[1]; v = f[0];
`ifdef EXEC_SEQ_COND_EN
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
`else
        base = 1'b1;
        return base | (^{c, z, cf, n, v} & 1'b0);
`endif
    endfunction

    // Transaction model: an op accepted at the end of cycle k is in EXEC at k+1, WB at k+2.
    logic        e_vld = 0, w_vld = 0;
    logic [3:0]  e_rd, w_rd, e_cond;
    logic        e_wb, e_setf, w_wb, w_setf, w_pass;
    logic [3:0]  last_rn = 0, last_rm = 0;
    logic [4:0]  last_uop = 0;
    logic [31:0] m_cnt = 0;
    logic        m_acc;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_ready", op_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_reg_we", reg_we, 0);
            chk("rst_flags_we", flags_we, 0);
            chk("rst_retire", retire, 0);
            chk("rst_count", op_count, 0);
            chk("rst_sel", {sel_p0, sel_p1, alu_uop}, 0);
            e_vld = 0; w_vld = 0; m_cnt = 0;
            last_rn = 0; last_rm = 0; last_uop = 0;
        end else begin
            chk("op_ready", op_ready, !e_vld);
            chk("busy", busy, e_vld | w_vld);
            chk("retire", retire, w_vld);
            chk("skipped", skipped, w_vld & !w_pass);
            chk("reg_we", reg_we, w_vld & w_wb & w_pass);
            chk("flags_we", flags_we, w_vld & w_setf & w_pass);
            chk("sel_p0", sel_p0, last_rn);
            chk("sel_p1", sel_p1, last_rm);
            chk("alu_uop", alu_uop, last_uop);
            chk("op_count", op_count, m_cnt[15:0]);
            chk("op_count_w4", op_count_n, m_cnt[3:0]);
            chk("ready_w4", op_ready_n, !e_vld);
            if (w_vld) chk("sel_in", sel_in, w_rd);
            if (w_vld) m_cnt = m_cnt + 1;
            w_vld = e_vld;
            w_rd = e_rd; w_wb = e_wb; w_setf = e_setf;
            w_pass = cond_ok(e_cond, flags);
            m_acc = op_valid & !e_vld;
            e_vld = m_acc;
            if (m_acc) begin
                e_rd = op_rd; e_wb = op_wb; e_setf = op_setf; e_cond = op_cond;
                last_rn = op_rn; last_rm = op_rm; last_uop = op_uop;
            end
        end
    end

    // Presents an op and returns #1 after the edge that accepted it (op is then in EXEC).
    task automatic issue(input logic [4:0] u, input logic [3:0] d, input logic [3:0] n,
                         input logic [3:0] m, input logic w, input logic s, input logic [3:0] c);
        logic got;
        got = 0;
        op_uop = u; op_rd = d; op_rn = n; op_rm = m; op_wb = w; op_setf = s; op_cond = c;
        op_valid = 1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            if (op_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no ready expected ready within 8 cycles");
        end
        @(posedge clock); #1;
        op_valid = 0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
        end
    endtask

    logic [6:0] exp_rdy, exp_ret;
    int         acc;
    logic       exp_skip;

    initial begin
        cycles(3);
        preload = 1; clr_flags = 1;
        cycles(1);
        preload = 0; clr_flags = 0;
        reset_n = 1;
        cycles(1);

        // SUB r2 = r1 - r0, then dependent ADD r3 = r2 + r2 accepted during WB
        issue(5'd1, 4'd2, 4'd1, 4'd0, 1, 1, 4'hE);
        cycles(1);
        chk("t2_sel_in", sel_in, 4'd2);
        chk("t2_reg_we", reg_we, 1);
        chk("t2_flags_we", flags_we, 1);
        issue(5'd0, 4'd3, 4'd2, 4'd2, 1, 0, 4'hE);
        cycles(3);
        chk("t2_r2", rf[2], 32'hFFFF_FFFF);
        chk("t2_N", fl_reg[1], 1);
        chk("t2_C", fl_reg[2], 0);
        chk("t4_r3", rf[3], 32'hFFFF_FFFE);

        // Back-to-back: valid held for three ops
        exp_rdy = 7'b1010101;
        exp_ret = 7'b1010100;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            op_valid = (acc < 3);
            op_uop = 5'd0; op_rd = 4'(6 + acc); op_rn = 4'd0; op_rm = 4'd1;
            op_wb = 1; op_setf = 0; op_cond = 4'hE;
            @(negedge clock);
            chk("t3_ready", op_ready, exp_rdy[c]);
            chk("t3_retire", retire, exp_ret[c]);
            if (op_valid && op_ready) acc++;
            @(posedge clock); #1;
        end
        op_valid = 0;
        chk("t3_count", op_count, 16'd5);

        // Condition gating with Z=0: EQ skipped (when enabled), NE written
        clr_flags = 1;
        cycles(1);
        clr_flags = 0;
`ifdef EXEC_SEQ_COND_EN
        exp_skip = 1;
`else
        exp_skip = 0;
`endif
        issue(5'd0, 4'd5, 4'd0, 4'd1, 1, 1, 4'h0);
        cycles(1);
        chk("t5_eq_retire", retire, 1);
        chk("t5_eq_skipped", skipped, exp_skip);
        chk("t5_eq_reg_we", reg_we, !exp_skip);
        chk("t5_eq_flags_we", flags_we, !exp_skip);
        issue(5'd0, 4'd5, 4'd0, 4'd1, 1, 1, 4'h1);
        cycles(1);
        chk("t5_ne_skipped", skipped, 0);
        chk("t5_ne_reg_we", reg_we, 1);
        cycles(2);
        chk("t5_r5", rf[5], 32'd3);

        // Asynchronous reset in the middle of WB
        issue(5'd0, 4'd9, 4'd0, 4'd1, 1, 1, 4'hE);
        cycles(1);
        chk("t1_pre_we", reg_we, 1);
        reset_n = 0;
        #1;
        chk("t1_reg_we", reg_we, 0);
        chk("t1_count", op_count, 0);
        chk("t1_ready", op_ready, 1);
        chk("t1_busy", busy, 0);
        cycles(2);
        chk("t1_no_write", rf[9], 32'd0);
        reset_n = 1;
        cycles(1);

        // Narrow counter wraps after 16 retirements
        for (int i = 1; i <= 17; i++) begin
            issue(5'd0, 4'd10, 4'd0, 4'd1, 0, 0, 4'hE);
            if (i == 16) chk("t6_at15", op_count_n, 4'hF);
            if (i == 17) chk("t6_at16", op_count_n, 4'h0);
        end
        cycles(2);
        chk("t6_wrap", op_count_n, 4'h1);
        chk("t6_wide", op_count, 16'd17);

        // Random traffic with random flags and one mid-run reset
        rand_mode = 1;
        for (int c = 0; c < 600; c++) begin
            op_valid  = ($urandom_range(0, 3) != 0);
            op_uop    = 5'($urandom);
            op_rd     = 4'($urandom);
            op_rn     = 4'($urandom);
            op_rm     = 4'($urandom);
            op_wb     = 1'($urandom);
            op_setf   = 1'($urandom);
            op_cond   = 4'($urandom);
            rnd_flags = 4'($urandom);
            reset_n   = !(c == 300 || c == 301);
            @(posedge clock); #1;
        end
        op_valid = 0;
        reset_n = 1;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
